// File: rtl/rx_nibble_deserializer.sv
// Serial receiver that unpacks one UART-style frame into four NIB_W-bit fields.
// Build with RX_PARITY_EN defined to expect an even-parity bit before the stop bit.
module rx_nibble_deserializer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int NIB_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    output logic [NIB_W-1:0] recevA,
    output logic [NIB_W-1:0] recevB,
    output logic [NIB_W-1:0] recevC,
    output logic [NIB_W-1:0] recevD,
    output logic             received,
    output logic             frame_err,
    output logic             parity_err,
    output logic             busy
);
    localparam int DW = 4 * NIB_W;
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DW);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DW - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     idx_q;
    logic [DW-1:0]     sh_q;
    logic [NIB_W-1:0]  rec_a_q, rec_b_q, rec_c_q, rec_d_q;
    logic              done_q;
    logic              received_q;
    logic              frame_err_q;
    logic              busy_q;

`ifdef RX_PARITY_EN
    logic              perr_pend_q;
    logic              parity_err_q;

    function automatic logic even_parity(input logic [DW-1:0] v);
        return ^v;
    endfunction
`endif

    // Receive FSM: START samples mid-bit, later bits are sampled one full bit period apart.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            rec_a_q     <= '0;
            rec_b_q     <= '0;
            rec_c_q     <= '0;
            rec_d_q     <= '0;
            done_q      <= 1'b0;
            received_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef RX_PARITY_EN
            perr_pend_q  <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            done_q      <= 1'b0;
            received_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // Good stop bit was seen last cycle; publish while the FSM is already back in IDLE.
            if (done_q) begin
                rec_a_q    <= sh_q[NIB_W-1:0];
                rec_b_q    <= sh_q[2*NIB_W-1:NIB_W];
                rec_c_q    <= sh_q[3*NIB_W-1:2*NIB_W];
                rec_d_q    <= sh_q[4*NIB_W-1:3*NIB_W];
                received_q <= 1'b1;
`ifdef RX_PARITY_EN
                parity_err_q <= perr_pend_q;
`endif
            end else begin
                received_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!serial_in) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        if (!serial_in) begin
                            state_q <= S_DATA;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q       <= '0;
                        sh_q[idx_q] <= serial_in;
                        if (idx_q == IDX_LAST) begin
                            idx_q   <= '0;
`ifdef RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`ifdef RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q       <= '0;
                        perr_pend_q <= serial_in ^ even_parity(sh_q);
                        state_q     <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (serial_in) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_BREAK: begin
                    cnt_q <= '0;
                    if (serial_in) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign recevA    = rec_a_q;
    assign recevB    = rec_b_q;
    assign recevC    = rec_c_q;
    assign recevD    = rec_d_q;
    assign received  = received_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
`ifdef RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_nibble_deserializer.sv
// Scoreboard bench for rx_nibble_deserializer: stimulus pushes expected frames, a monitor checks every cycle.
module tb_rx_nibble_deserializer;
    localparam int CPB = 4;
    localparam int NW  = 4;
    localparam int DW  = 4 * NW;
`ifdef RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int LAT = CPB / 2 + (DW + 1 + PB) * CPB + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serial_in = 1'b1;
    logic [NW-1:0] recevA, recevB, recevC, recevD;
    logic received, frame_err, parity_err, busy;

    rx_nibble_deserializer #(.CLKS_PER_BIT(CPB), .NIB_W(NW)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .recevA     (recevA),
        .recevB     (recevB),
        .recevC     (recevC),
        .recevD     (recevD),
        .received   (received),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
        int            start_cyc;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            failures = 0;
    int            exp_ferr = 0;
    int            cyc = 0;
    logic          rst_at_edge = 1'b1;
    logic [DW-1:0] model_out = '0;
    logic          prev_rcv = 1'b0;
    logic          prev_ferr = 1'b0;

    localparam logic [DW-1:0] F1 = {4'b0101, 4'b1111, 4'b1000, 4'b0110};
    localparam logic [DW-1:0] F2 = {4'b0111, 4'b1001, 4'b1010, 4'b0000};
    localparam logic [DW-1:0] F3 = 16'h1234;
    localparam logic [DW-1:0] F4 = {4'b1111, 4'b1101, 4'b0000, 4'b0100};

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on received, otherwise demands stable outputs.
    always @(negedge clk) begin
        logic [DW-1:0] outv;
        exp_t e;
        outv = {recevD, recevC, recevB, recevA};
        if (rst_at_edge) begin
            model_out = '0;
            check("reset_state", 32'({outv, received, frame_err, parity_err, busy}), 32'd0);
        end else begin
            if (received) begin
                if (sb.size() == 0) begin
                    check("unexpected_received", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("frame_data", 32'(outv), 32'(e.data));
                    check("parity_err", 32'(parity_err), 32'(e.perr));
                    check("latency", 32'(cyc - e.start_cyc), 32'(LAT));
                    model_out = e.data;
                end
            end else begin
                check("outputs_stable", 32'(outv), 32'(model_out));
                check("parity_err_alone", 32'(parity_err), 32'd0);
            end
            if (frame_err) begin
                if (exp_ferr == 0) begin
                    check("unexpected_frame_err", 32'd1, 32'd0);
                end else begin
                    exp_ferr--;
                    check("ferr_outputs_held", 32'(outv), 32'(model_out));
                end
            end
            check("pulse_width", 32'({prev_rcv & received, prev_ferr & frame_err}), 32'd0);
        end
        prev_rcv  = received;
        prev_ferr = frame_err;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop, input logic flip,
                              input int abort_bit);
        int   st;
        exp_t e;
        serial_in = 1'b0;
        st = cyc + 1;
        tick(CPB);
        for (int i = 0; i < DW; i++) begin
            if (i == abort_bit) begin
                serial_in = d[i];
                tick(2);
                rst = 1'b1;
                tick(2);
                rst = 1'b0;
                serial_in = 1'b1;
                tick(4);
                return;
            end
            send_bit(d[i]);
        end
`ifdef RX_PARITY_EN
        send_bit((^d) ^ flip);
`endif
        if (stop) begin
            e.data = d;
            e.perr = flip;
            e.start_cyc = st;
            sb.push_back(e);
        end else begin
            exp_ferr++;
        end
        send_bit(stop);
    endtask

    initial begin
        rst = 1'b1;
        serial_in = 1'b1;
        tick(3);
        rst = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_fields", 32'({recevD, recevC, recevB, recevA}), 32'd0);
        tick(100);

        send_frame(F1, 1'b1, 1'b0, -1);
        send_frame(F2, 1'b1, 1'b0, -1);
        tick(4);

        serial_in = 1'b0;
        tick(1);
        check("glitch_busy_high", 32'(busy), 32'd1);
        serial_in = 1'b1;
        tick(3);
        check("glitch_busy_low", 32'(busy), 32'd0);
        tick(8);

        send_frame(F3, 1'b0, 1'b0, -1);
        tick(20);
        check("break_busy", 32'(busy), 32'd1);
        serial_in = 1'b1;
        tick(2);
        check("break_exit", 32'(busy), 32'd0);
        check("frame_err_seen", 32'(exp_ferr), 32'd0);
        tick(4);

        send_frame(F4, 1'b1, 1'b0, 7);
        check("abort_fields", 32'({recevD, recevC, recevB, recevA}), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        send_frame(F4, 1'b1, 1'b0, -1);
        tick(8);

`ifdef RX_PARITY_EN
        send_frame(F1, 1'b1, 1'b0, -1);
        send_frame(F2, 1'b1, 1'b1, -1);
        tick(8);
`endif

        for (int i = 0; i < 200 && sb.size() > 0; i++) begin
            tick(1);
        end
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("frame_err_drained", 32'(exp_ferr), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
